// File: rtl/pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : pixel_scheduler
// Purpose : Raster-order Mandelbrot frame sequencer; round-robin dispatch to
//           NUM_ENGINES engines, in-order retire to the pixel packer.
//           Optional macro CONTINUOUS_EN re-runs the latched frame forever.
// Rev     : 1.0
// ============================================================================
module pixel_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int X_W         = 11,
    parameter int Y_W         = 10
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start,
    input  logic [X_W-1:0]            hres,
    input  logic [Y_W-1:0]            vres,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_ENGINES-1:0]    eng_req_valid,
    input  logic [NUM_ENGINES-1:0]    eng_req_ready,
    output logic [X_W-1:0]            eng_x,
    output logic [Y_W-1:0]            eng_y,
    input  logic [NUM_ENGINES-1:0]    eng_rsp_valid,
    input  logic [24*NUM_ENGINES-1:0] eng_rsp_rgb,
    output logic [NUM_ENGINES-1:0]    eng_rsp_ready,
    output logic                      pix_valid,
    output logic                      pix_sof,
    output logic                      pix_eol,
    output logic [7:0]                pix_r,
    output logic [7:0]                pix_g,
    output logic [7:0]                pix_b,
    input  logic                      pix_ready
);

    localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [X_W-1:0]         hres_q;
    logic [Y_W-1:0]         vres_q;
    logic [X_W-1:0]         dx;
    logic [Y_W-1:0]         dy;
    logic [X_W-1:0]         rx;
    logic [Y_W-1:0]         ry;
    logic [PW-1:0]          d_ptr;
    logic [PW-1:0]          r_ptr;
    logic [NUM_ENGINES-1:0] outstanding;

    logic                   retiring_state;
    logic                   ret_valid;
    logic                   disp_fire;
    logic                   ret_fire;
    logic                   dx_end;
    logic                   rx_end;
    logic [NUM_ENGINES-1:0] disp_mask;
    logic [NUM_ENGINES-1:0] ret_mask;
    logic [23:0]            rsp_sel;

    assign retiring_state = (state == S_RUN) || (state == S_DRAIN);
    assign dx_end         = (dx == hres_q - 1'b1);
    assign rx_end         = (rx == hres_q - 1'b1);

    // Only the engine at the head of each pointer is ever offered a handshake,
    // which is what keeps retirement in raster order.
    always_comb begin
        eng_req_valid = '0;
        eng_rsp_ready = '0;
        if (state == S_RUN)
            eng_req_valid[d_ptr] = !outstanding[d_ptr];
        if (retiring_state)
            eng_rsp_ready[r_ptr] = outstanding[r_ptr] & pix_ready;
    end

    assign rsp_sel   = eng_rsp_rgb[24*r_ptr +: 24];
    assign ret_valid = retiring_state && outstanding[r_ptr] && eng_rsp_valid[r_ptr];
    assign disp_mask = eng_req_valid & eng_req_ready;
    assign ret_mask  = eng_rsp_ready & eng_rsp_valid;
    assign disp_fire = |disp_mask;
    assign ret_fire  = ret_valid & pix_ready;

    assign eng_x     = dx;
    assign eng_y     = dy;
    assign pix_valid = ret_valid;
    assign pix_sof   = ret_valid && (rx == '0) && (ry == '0);
    assign pix_eol   = ret_valid && rx_end;
    assign pix_r     = ret_valid ? rsp_sel[23:16] : 8'd0;
    assign pix_g     = ret_valid ? rsp_sel[15:8]  : 8'd0;
    assign pix_b     = ret_valid ? rsp_sel[7:0]   : 8'd0;

    assign done      = (state == S_DONE);
`ifdef CONTINUOUS_EN
    assign busy      = (state != S_IDLE);
`else
    assign busy      = retiring_state;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= S_IDLE;
            hres_q      <= '0;
            vres_q      <= '0;
            dx          <= '0;
            dy          <= '0;
            rx          <= '0;
            ry          <= '0;
            d_ptr       <= '0;
            r_ptr       <= '0;
            outstanding <= '0;
        end else begin
            outstanding <= (outstanding | disp_mask) & ~ret_mask;

            if (disp_fire) begin
                d_ptr <= (d_ptr == PW'(NUM_ENGINES-1)) ? '0 : d_ptr + 1'b1;
                if (dx_end) begin
                    dx <= '0;
                    dy <= dy + 1'b1;
                end else begin
                    dx <= dx + 1'b1;
                end
            end

            if (ret_fire) begin
                r_ptr <= (r_ptr == PW'(NUM_ENGINES-1)) ? '0 : r_ptr + 1'b1;
                if (rx_end) begin
                    rx <= '0;
                    ry <= ry + 1'b1;
                end else begin
                    rx <= rx + 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start && (hres != '0) && (vres != '0)) begin
                        hres_q <= hres;
                        vres_q <= vres;
                        dx     <= '0;
                        dy     <= '0;
                        rx     <= '0;
                        ry     <= '0;
                        d_ptr  <= '0;
                        r_ptr  <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (disp_fire && dx_end && (dy == vres_q - 1'b1))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (ret_fire && rx_end && (ry == vres_q - 1'b1))
                        state <= S_DONE;
                end
                S_DONE: begin
`ifdef CONTINUOUS_EN
                    dx    <= '0;
                    dy    <= '0;
                    rx    <= '0;
                    ry    <= '0;
                    d_ptr <= '0;
                    r_ptr <= '0;
                    state <= S_RUN;
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
